// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation encoding for the alu_pipe slice
// Contents: alu_op_t (2-bit operation select used on the op port and in S1).
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_XOR = 2'd2,
        ALU_AND = 2'd3
    } alu_op_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
// Ports (slave = the pipeline):
//   in_valid/in_ready, a, b, op       operand side
//   out_valid/out_ready, result,
//   carry, ovf, zero                  result side
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_t          op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, ovf, zero
    );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU placed between the S1 and S2 registers
// Ports:
//   a, b     operands (WIDTH bits)
//   op       alu_op_t select
//   result   a op b modulo 2^WIDTH
//   carry    ADD carry-out / SUB borrow / 0 for logic ops
//   ovf      signed overflow for ADD/SUB, 0 for logic ops
//   zero     result == 0
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the top bit is "no borrow", so it is inverted for carry.
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (op)
            ALU_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = ~diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_XOR: result = a ^ b;
            ALU_AND: result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline (S1 operands, S2 results)
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      alu_pipe_if.slave: operand handshake in, result handshake out
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_t          s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_carry;
    logic             s2_ovf;
    logic             s2_zero;

    logic [WIDTH-1:0] c_result;
    logic             c_carry;
    logic             c_ovf;
    logic             c_zero;

    logic             s2_ready;
    logic             s1_ready;

    // A stage may load when empty or when its contents leave this same edge;
    // chaining the two gives full throughput with no bubble under back-pressure.
    assign s2_ready = !s2_valid || bus.out_ready;
    assign s1_ready = !s1_valid || s2_ready;

    assign bus.in_ready = s1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= ALU_ADD;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_op <= bus.op;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (c_result),
        .carry  (c_carry),
        .ovf    (c_ovf),
        .zero   (c_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_carry  <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_zero   <= 1'b1;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= c_result;
                s2_carry  <= c_carry;
                s2_ovf    <= c_ovf;
                s2_zero   <= c_zero;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.carry     = s2_carry;
    assign bus.ovf       = s2_ovf;
    assign bus.zero      = s2_zero;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=4)
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [3:0] res;
        logic       c;
        logic       v;
        logic       z;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    exp_t       q[$];
    logic [3:0] obs_res[$];
    logic       obs_c[$];
    logic       obs_v[$];
    logic       obs_z[$];
    int         obs_cyc[$];

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input alu_op_t o, input int x, input int y);
        exp_t e;
        int   sx, sy, r, sr;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        e.c = 1'b0;
        e.v = 1'b0;
        r   = 0;
        case (o)
            ALU_ADD: begin r = x + y; sr = sx + sy; e.c = (r > 15); e.v = (sr > 7) || (sr < -8); end
            ALU_SUB: begin r = x - y; sr = sx - sy; e.c = (x < y);  e.v = (sr > 7) || (sr < -8); end
            ALU_XOR: r = x ^ y;
            ALU_AND: r = x & y;
            default: r = 0;
        endcase
        e.res = 4'(r & 15);
        e.z   = (e.res == 4'h0);
        e.cyc = 0;
        return e;
    endfunction

    // Compare process: sample mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_carry", bus.carry, 0);
            chk("rst_ovf", bus.ovf, 0);
            chk("rst_zero", bus.zero, 1);
            q.delete();
        end else if (mon_en) begin
            chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
            chk("out_valid", bus.out_valid, (q.size() > 0) && (cyc >= q[0].cyc + 2));
            if (bus.out_valid && q.size() > 0) begin
                chk("result", bus.result, q[0].res);
                chk("carry", bus.carry, q[0].c);
                chk("ovf", bus.ovf, q[0].v);
                chk("zero", bus.zero, q[0].z);
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_res.push_back(bus.result);
                obs_c.push_back(bus.carry);
                obs_v.push_back(bus.ovf);
                obs_z.push_back(bus.zero);
                obs_cyc.push_back(cyc);
                if (q.size() > 0) void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                e     = model(bus.op, int'(bus.a), int'(bus.b));
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input alu_op_t o, input logic [3:0] x, input logic [3:0] y);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_res.delete();
        obs_c.delete();
        obs_v.delete();
        obs_z.delete();
        obs_cyc.delete();
    endtask

    initial begin
        exp_t e;
        bit   done;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = ALU_ADD;
        bus.out_ready = 1'b1;

        // Pin the model against hand-computed values.
        e = model(ALU_ADD, 3, 2);    chk("model_add_res", e.res, 4'h5);
        e = model(ALU_SUB, 5, 10);   chk("model_sub_res", e.res, 4'hB); chk("model_sub_c", e.c, 1);
        chk("model_sub_v", e.v, 1);
        e = model(ALU_ADD, 7, 1);    chk("model_add_v", e.v, 1); chk("model_add_res8", e.res, 4'h8);
        e = model(ALU_ADD, 15, 1);   chk("model_wrap_z", e.z, 1); chk("model_wrap_c", e.c, 1);
        e = model(ALU_AND, 12, 10);  chk("model_and_res", e.res, 4'h8);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back mixed ops with the consumer always ready.
        clear_obs();
        send(ALU_ADD, 4'h3, 4'h2);
        send(ALU_XOR, 4'h7, 4'h8);
        send(ALU_ADD, 4'hE, 4'h1);
        send(ALU_SUB, 4'h5, 4'hA);
        drain();
        chk("seq_count", obs_res.size(), 4);
        if (obs_res.size() == 4) begin
            chk("seq_r0", obs_res[0], 4'h5); chk("seq_c0", obs_c[0], 0);
            chk("seq_r1", obs_res[1], 4'hF); chk("seq_c1", obs_c[1], 0);
            chk("seq_r2", obs_res[2], 4'hF); chk("seq_c2", obs_c[2], 0);
            chk("seq_r3", obs_res[3], 4'hB); chk("seq_c3", obs_c[3], 1);
            chk("seq_rate", obs_cyc[3] - obs_cyc[0], 3);
        end

        // Overflow and wrap boundaries, AND results.
        clear_obs();
        send(ALU_ADD, 4'h7, 4'h1);
        send(ALU_ADD, 4'hF, 4'h1);
        send(ALU_AND, 4'hC, 4'hA);
        send(ALU_AND, 4'h5, 4'hA);
        drain();
        chk("edge_count", obs_res.size(), 4);
        if (obs_res.size() == 4) begin
            chk("ovf_r", obs_res[0], 4'h8); chk("ovf_v", obs_v[0], 1); chk("ovf_c", obs_c[0], 0);
            chk("wrap_r", obs_res[1], 4'h0); chk("wrap_c", obs_c[1], 1);
            chk("wrap_z", obs_z[1], 1); chk("wrap_v", obs_v[1], 0);
            chk("and_r", obs_res[2], 4'h8); chk("and_z", obs_z[2], 0);
            chk("and_c", obs_c[2], 0); chk("and_v", obs_v[2], 0);
            chk("and0_r", obs_res[3], 4'h0); chk("and0_z", obs_z[3], 1);
        end

        // Back-pressure: two held, third stalls, then release.
        clear_obs();
        bus.out_ready = 1'b0;
        send(ALU_ADD, 4'h1, 4'h1);
        send(ALU_ADD, 4'h2, 4'h2);
        bus.in_valid = 1'b1;
        bus.op       = ALU_ADD;
        bus.a        = 4'h3;
        bus.b        = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", bus.in_ready, 0);
            chk("held_result", bus.result, 4'h2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(ALU_ADD, 4'h3, 4'h3);
        drain();
        chk("bp_count", obs_res.size(), 3);
        if (obs_res.size() == 3) begin
            chk("bp_r0", obs_res[0], 4'h2);
            chk("bp_r1", obs_res[1], 4'h4);
            chk("bp_r2", obs_res[2], 4'h6);
            chk("bp_rate", obs_cyc[2] - obs_cyc[0], 2);
        end

        // Reset with two operations in flight.
        clear_obs();
        bus.out_ready = 1'b0;
        send(ALU_ADD, 4'h4, 4'h4);
        send(ALU_XOR, 4'h9, 4'h3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_immediate_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_no_output", obs_res.size(), 0);
        @(posedge clk);
        #1;

        // Random valid/ready traffic checked by the compare process.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(alu_op_t'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set on a, b, op is valid this cycle.
REQ-005 Port: in_ready  output  1  block accepts an operand set this cycle.
REQ-006 Port: a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: op  input  2  operation select, alu_op_t encoding.
REQ-009 Port: out_valid  output  1  result, carry, ovf and zero are valid.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: result  output  WIDTH  operation result, modulo 2^WIDTH.
REQ-012 Port: carry  output  1  ADD: carry-out; SUB: borrow (1 when a < b unsigned); XOR/AND: 0.
REQ-013 Port: ovf  output  1  signed overflow for ADD/SUB; 0 for XOR/AND.
REQ-014 Port: zero  output  1  1 when result == 0.

Function
REQ-015 op encoding: 0 ADD (a+b), 1 SUB (a-b), 2 XOR (a^b), 3 AND (a&b).
REQ-016 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-017 Two register stages: S1 captures a, b, op; S2 captures computed result and flags.
REQ-018 Latency: an accepted operand set appears on outputs exactly 2 cycles later when out_ready is held high.
REQ-019 Throughput: one transfer per cycle, sustained, when out_ready is high.
REQ-020 Stage advance rule: a stage loads when it is empty or its contents move forward in the same cycle.
REQ-021 in_ready = !S1_valid || S1 advancing; combinational from out_ready, no bubble under back-pressure.
REQ-022 With out_ready low, at most 2 transactions are held; in_ready deasserts when both stages are full.
REQ-023 Outputs remain stable while out_valid && !out_ready.
REQ-024 Results leave in acceptance order; no loss, no duplication.
REQ-025 Simultaneous accept on input and output when full: S2 takes S1, S1 takes the new input in the same edge.
REQ-026 ADD/SUB computed at WIDTH+1 bits; carry is bit WIDTH (inverted for SUB to give borrow).
REQ-027 ovf = operand sign bits agree (ADD) or differ (SUB) and result sign differs from a.
REQ-028 in_valid with in_ready low: inputs ignored; the source holds them.

Reset
REQ-029 While rst_n is low: S1_valid, S2_valid, out_valid = 0; result = 0; carry, ovf = 0; zero = 1.
REQ-030 in_ready = 1 from the first cycle after rst_n deasserts.
REQ-031 Reset mid-operation discards all in-flight transactions; no partial result is emitted.

Structure
REQ-032 Package alu_pkg holds typedef enum logic [1:0] alu_op_t {ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND}.
REQ-033 Sub-module alu_core: combinational, parametrised by WIDTH; maps a, b, op to result, carry, ovf, zero; placed between S1 and S2.
REQ-034 All pipeline registers use one always_ff block per stage, with async reset on negedge rst_n.

Verification (WIDTH=4)
REQ-035 Sequence ADD 3+2, XOR 7^8, ADD E+1, SUB 5-A, out_ready=1 -> results 5, F, F, B 2 cycles after each accept; SUB carry=1, others carry=0.
REQ-036 ADD 7+1 -> result 8, ovf=1, carry=0; ADD F+1 -> result 0, carry=1, zero=1, ovf=0.
REQ-037 out_ready low, 3 back-to-back inputs -> in_ready low after 2 accepts; third input held; release -> all 3 results in order, 1 per cycle.
REQ-038 Random valid/ready toggling, 1000 ops -> scoreboard matches the reference model in order with zero mismatches.
REQ-039 rst_n low for 1 cycle with 2 ops in flight -> out_valid=0 immediately, no stale result afterwards, in_ready=1 next cycle.
REQ-040 AND C&A -> result 8, carry=0, ovf=0, zero=0; AND 5&A -> result 0, zero=1.
